sha256_hash_id_tagger: RTL and testbench

//  Engine-side counterpart of the packet manager's ID validator. Accepts one

---
 rtl/sha256_hash_id_tagger_if.sv | 42 ++++
 rtl/sha256_hash_id_tagger.sv | 102 ++++++++++
 tb/tb_sha256_hash_id_tagger.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_hash_id_tagger_if.sv
// Stream bundle between the SHA-256 engine side (cfg + per-block digests)
// and the ID validator (tagged final hash).
interface sha256_hash_id_tagger_if #(
  parameter int ID_WIDTH     = 6,
  parameter int DIGEST_WIDTH = 256,
  parameter int SIZE_WIDTH   = 64
);
  logic [SIZE_WIDTH-1:0]   cfg_in_size;
  logic [ID_WIDTH-1:0]     cfg_in_id;
  logic                    cfg_in_last;
  logic                    cfg_in_valid;
  logic                    cfg_in_ready;
  logic [DIGEST_WIDTH-1:0] digest_in;
  logic                    digest_in_valid;
  logic                    digest_in_ready;
  logic [DIGEST_WIDTH-1:0] hash_out;
  logic [ID_WIDTH-1:0]     hash_out_id;
  logic                    hash_out_last;
  logic                    hash_out_valid;
  logic                    hash_out_ready;
  logic [SIZE_WIDTH-9:0]   status_blocks_remaining;

  modport master (
    output cfg_in_size, cfg_in_id, cfg_in_last, cfg_in_valid,
    input  cfg_in_ready,
    output digest_in, digest_in_valid,
    input  digest_in_ready,
    input  hash_out, hash_out_id, hash_out_last, hash_out_valid,
    output hash_out_ready,
    input  status_blocks_remaining
  );

  modport slave (
    input  cfg_in_size, cfg_in_id, cfg_in_last, cfg_in_valid,
    output cfg_in_ready,
    input  digest_in, digest_in_valid,
    output digest_in_ready,
    output hash_out, hash_out_id, hash_out_last, hash_out_valid,
    input  hash_out_ready,
    output status_blocks_remaining
  );
endinterface

// File: rtl/sha256_hash_id_tagger.sv
// Counts per-block digests of one message, drops the intermediates and emits
// the final digest tagged with the message ID and last flag.
//
//   state    | meaning
//   S_IDLE   | waiting for a config word (cfg_in_ready = en)
//   S_COUNT  | accepting block digests until remaining reaches 1
//   S_OUTPUT | final hash presented, waiting for hash_out_ready
module sha256_hash_id_tagger #(
  parameter int ID_WIDTH     = 6,
  parameter int DIGEST_WIDTH = 256,
  parameter int SIZE_WIDTH   = 64
) (
  input logic                    clk,
  input logic                    nrst,
  input logic                    en,
  input logic                    sync_rst,
  sha256_hash_id_tagger_if.slave bus
);
  localparam int CNT_WIDTH = SIZE_WIDTH - 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;
  localparam logic [SIZE_WIDTH:0] PAD_ROUND = 576;

  logic [1:0]              state;
  logic [CNT_WIDTH-1:0]    remaining;
  logic [DIGEST_WIDTH-1:0] hash_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic                    last_q;
  logic                    valid_q;
  logic [SIZE_WIDTH:0]     size_sum;
  logic [SIZE_WIDTH:0]     size_shr;
  logic [CNT_WIDTH-1:0]    n_blocks;
  logic                    cfg_xfer;
  logic                    dig_xfer;
  logic                    out_xfer;

  // One extra bit keeps the padding round-up from wrapping at max size.
  assign size_sum = {1'b0, bus.cfg_in_size} + PAD_ROUND;
  assign size_shr = size_sum >> 9;
  assign n_blocks = size_shr[CNT_WIDTH-1:0];

  assign bus.cfg_in_ready    = en && (state == S_IDLE);
  assign bus.digest_in_ready = en && (state == S_COUNT);
  assign cfg_xfer = bus.cfg_in_ready && bus.cfg_in_valid;
  assign dig_xfer = bus.digest_in_ready && bus.digest_in_valid;
  assign out_xfer = en && (state == S_OUTPUT) && bus.hash_out_ready;

  assign bus.hash_out                = hash_q;
  assign bus.hash_out_id             = id_q;
  assign bus.hash_out_last           = last_q;
  assign bus.hash_out_valid          = valid_q;
  assign bus.status_blocks_remaining = remaining;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      remaining <= '0;
      hash_q    <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (sync_rst) begin
      state     <= S_IDLE;
      remaining <= '0;
      hash_q    <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (cfg_xfer) begin
            remaining <= n_blocks;
            id_q      <= bus.cfg_in_id;
            last_q    <= bus.cfg_in_last;
            state     <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (dig_xfer) begin
            if (remaining == CNT_WIDTH'(1)) begin
              hash_q    <= bus.digest_in;
              valid_q   <= 1'b1;
              remaining <= '0;
              state     <= S_OUTPUT;
            end else begin
              remaining <= remaining - CNT_WIDTH'(1);
            end
          end
        end
        S_OUTPUT: begin
          if (out_xfer) begin
            valid_q <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_hash_id_tagger.sv
// Directed bench for sha256_hash_id_tagger: table of messages plus
// hand-written stall, sync_rst, enable-gating and max-size sequences.
module tb_sha256_hash_id_tagger;
  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic sync_rst;

  always #5 clk = ~clk;

  sha256_hash_id_tagger_if #(.ID_WIDTH(6), .DIGEST_WIDTH(256), .SIZE_WIDTH(64)) bus ();

  sha256_hash_id_tagger #(.ID_WIDTH(6), .DIGEST_WIDTH(256), .SIZE_WIDTH(64)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  typedef struct {
    logic [63:0] size;
    logic [5:0]  id;
    logic        last;
    logic [55:0] blocks;
  } vec_t;

  vec_t vecs[8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] dval(input int v, input int k);
    logic [7:0] vb;
    logic [7:0] kb;
    vb = v[7:0];
    kb = k[7:0];
    return {8{vb, kb, 16'hA5C3}};
  endfunction

  task automatic send_cfg(input logic [63:0] size, input logic [5:0] id, input logic last);
    bus.cfg_in_size  = size;
    bus.cfg_in_id    = id;
    bus.cfg_in_last  = last;
    bus.cfg_in_valid = 1'b1;
    for (int t = 0; t < 50 && !bus.cfg_in_ready; t++) begin
      @(posedge clk); #1;
    end
    check("cfg_ready_wait", bus.cfg_in_ready, 1'b1);
    @(posedge clk); #1;
    bus.cfg_in_valid = 1'b0;
  endtask

  task automatic send_digest(input logic [255:0] d);
    bus.digest_in       = d;
    bus.digest_in_valid = 1'b1;
    for (int t = 0; t < 50 && !bus.digest_in_ready; t++) begin
      @(posedge clk); #1;
    end
    check("digest_ready_wait", bus.digest_in_ready, 1'b1);
    @(posedge clk); #1;
    bus.digest_in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.hash_out_ready = 1'b1;
    @(posedge clk); #1;
    bus.hash_out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] d_last;
    logic [255:0] d_hold;
    int nb;

    // size -> blocks is (size + 65 + 511) >> 9
    vecs[0] = '{64'd0,     6'd1,  1'b0, 56'd1};
    vecs[1] = '{64'd512,   6'd2,  1'b0, 56'd2};
    vecs[2] = '{64'd960,   6'd3,  1'b0, 56'd3};
    vecs[3] = '{64'd1536,  6'd4,  1'b1, 56'd4};
    vecs[4] = '{64'd447,   6'd10, 1'b1, 56'd1};
    vecs[5] = '{64'd448,   6'd9,  1'b0, 56'd2};
    vecs[6] = '{64'd511,   6'd63, 1'b1, 56'd2};
    vecs[7] = '{64'd65536, 6'd0,  1'b0, 56'd129};

    bus.cfg_in_size     = '0;
    bus.cfg_in_id       = '0;
    bus.cfg_in_last     = 1'b0;
    bus.cfg_in_valid    = 1'b0;
    bus.digest_in       = '0;
    bus.digest_in_valid = 1'b0;
    bus.hash_out_ready  = 1'b0;
    en       = 1'b1;
    sync_rst = 1'b0;
    nrst     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hash", bus.hash_out, 256'd0);
    check("rst_id", bus.hash_out_id, 6'd0);
    check("rst_last", bus.hash_out_last, 1'b0);
    check("rst_valid", bus.hash_out_valid, 1'b0);
    check("rst_status", bus.status_blocks_remaining, 56'd0);
    nrst = 1'b1;
    @(posedge clk); #1;
    check("idle_cfg_ready", bus.cfg_in_ready, 1'b1);
    check("idle_digest_ready", bus.digest_in_ready, 1'b0);

    for (int i = 0; i < 8; i++) begin
      nb = int'(vecs[i].blocks);
      send_cfg(vecs[i].size, vecs[i].id, vecs[i].last);
      check("vec_status_start", bus.status_blocks_remaining, vecs[i].blocks);
      check("vec_count_cfg_ready", bus.cfg_in_ready, 1'b0);
      check("vec_count_digest_ready", bus.digest_in_ready, 1'b1);
      for (int k = 0; k < nb; k++) begin
        send_digest(dval(i, k));
        if (k < nb - 1) begin
          check("vec_status_mid", bus.status_blocks_remaining, vecs[i].blocks - 56'(k + 1));
          check("vec_valid_mid", bus.hash_out_valid, 1'b0);
        end
      end
      d_last = dval(i, nb - 1);
      check("vec_valid", bus.hash_out_valid, 1'b1);
      check("vec_hash", bus.hash_out, d_last);
      check("vec_id", bus.hash_out_id, vecs[i].id);
      check("vec_last", bus.hash_out_last, vecs[i].last);
      check("vec_status_end", bus.status_blocks_remaining, 56'd0);
      check("vec_out_digest_ready", bus.digest_in_ready, 1'b0);
      check("vec_out_cfg_ready", bus.cfg_in_ready, 1'b0);
      drain();
      check("vec_valid_drop", bus.hash_out_valid, 1'b0);
      check("vec_bubble_cfg_ready", bus.cfg_in_ready, 1'b1);
      check("vec_hash_hold", bus.hash_out, d_last);
    end

    // Output stall with the next config already waiting.
    send_cfg(64'd1024, 6'd7, 1'b1);
    check("stall_status", bus.status_blocks_remaining, 56'd3);
    for (int k = 0; k < 3; k++) send_digest(dval(40, k));
    d_hold = dval(40, 2);
    bus.cfg_in_size  = 64'd0;
    bus.cfg_in_id    = 6'd12;
    bus.cfg_in_last  = 1'b0;
    bus.cfg_in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("stall_valid", bus.hash_out_valid, 1'b1);
      check("stall_hash", bus.hash_out, d_hold);
      check("stall_id", bus.hash_out_id, 6'd7);
      check("stall_digest_ready", bus.digest_in_ready, 1'b0);
      check("stall_cfg_ready", bus.cfg_in_ready, 1'b0);
    end
    drain();
    check("stall_bubble_cfg_ready", bus.cfg_in_ready, 1'b1);
    @(posedge clk); #1;
    bus.cfg_in_valid = 1'b0;
    check("stall_next_status", bus.status_blocks_remaining, 56'd1);
    check("stall_next_digest_ready", bus.digest_in_ready, 1'b1);
    send_digest(dval(41, 0));
    check("stall_next_hash", bus.hash_out, dval(41, 0));
    check("stall_next_id", bus.hash_out_id, 6'd12);
    drain();

    // sync_rst mid-count overrides a pending digest transfer.
    send_cfg(64'd1024, 6'd20, 1'b1);
    send_digest(dval(50, 0));
    check("srst_pre_status", bus.status_blocks_remaining, 56'd2);
    bus.digest_in       = dval(50, 1);
    bus.digest_in_valid = 1'b1;
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    bus.digest_in_valid = 1'b0;
    check("srst_status", bus.status_blocks_remaining, 56'd0);
    check("srst_valid", bus.hash_out_valid, 1'b0);
    check("srst_hash", bus.hash_out, 256'd0);
    check("srst_id", bus.hash_out_id, 6'd0);
    check("srst_last", bus.hash_out_last, 1'b0);
    check("srst_cfg_ready", bus.cfg_in_ready, 1'b1);
    check("srst_digest_ready", bus.digest_in_ready, 1'b0);
    send_cfg(64'd0, 6'd21, 1'b0);
    send_digest(dval(51, 0));
    check("srst_after_hash", bus.hash_out, dval(51, 0));
    check("srst_after_id", bus.hash_out_id, 6'd21);
    check("srst_after_valid", bus.hash_out_valid, 1'b1);
    drain();

    // en=0 freezes COUNT and OUTPUT even with valids asserted.
    send_cfg(64'd448, 6'd3, 1'b1);
    en = 1'b0;
    bus.digest_in       = dval(60, 0);
    bus.digest_in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("en0_count_status", bus.status_blocks_remaining, 56'd2);
      check("en0_count_digest_ready", bus.digest_in_ready, 1'b0);
      check("en0_count_cfg_ready", bus.cfg_in_ready, 1'b0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    bus.digest_in_valid = 1'b0;
    check("en1_count_status", bus.status_blocks_remaining, 56'd1);
    send_digest(dval(60, 1));
    en = 1'b0;
    bus.hash_out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("en0_out_valid", bus.hash_out_valid, 1'b1);
      check("en0_out_hash", bus.hash_out, dval(60, 1));
      check("en0_out_cfg_ready", bus.cfg_in_ready, 1'b0);
    end
    en = 1'b1;
    @(posedge clk); #1;
    bus.hash_out_ready = 1'b0;
    check("en1_out_valid", bus.hash_out_valid, 1'b0);
    check("en1_out_cfg_ready", bus.cfg_in_ready, 1'b1);

    // Largest size: (2^64 - 1 + 576) >> 9 needs the 65th bit.
    send_cfg(64'hFFFF_FFFF_FFFF_FFFF, 6'h2A, 1'b0);
    check("max_size_status", bus.status_blocks_remaining, 56'h80_0000_0000_0001);
    check("max_size_id", bus.hash_out_id, 6'h2A);
    sync_rst = 1'b1;
    @(posedge clk); #1;
    sync_rst = 1'b0;
    check("max_size_cleared", bus.status_blocks_remaining, 56'd0);

    // Asynchronous reset while a hash is presented.
    send_cfg(64'd0, 6'd33, 1'b1);
    send_digest(dval(70, 0));
    check("arst_pre_valid", bus.hash_out_valid, 1'b1);
    #2 nrst = 1'b0;
    #1;
    check("arst_valid", bus.hash_out_valid, 1'b0);
    check("arst_hash", bus.hash_out, 256'd0);
    check("arst_id", bus.hash_out_id, 6'd0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    check("arst_cfg_ready", bus.cfg_in_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
